// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the memory access controller.
// The VERIFY state exists only when MEM_CTRL_VERIFY_EN is defined.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;

`ifdef MEM_CTRL_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    VERIFY,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    READ,
    DONE
  } state_t;
`endif

  // States in which the cell array is addressed and CS/D are driven.
  function automatic logic in_access(state_t s);
    logic hit;
    hit = (s == SETUP) || (s == WRITE) || (s == READ);
`ifdef MEM_CTRL_VERIFY_EN
    hit = hit || (s == VERIFY);
`endif
    return hit;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_addr_decoder.sv
// One-hot word select decoder for the cell array; all outputs low when disabled.
import mem_ctrl_pkg::*;

module addr_decoder #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [2**ADDR_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Host-to-cell-array access sequencer: IDLE -> SETUP -> WRITE/READ -> DONE.
// Define MEM_CTRL_VERIFY_EN to add a read-back VERIFY step after each write (drives ERR).
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     ADDR,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W-1:0]     Q,
  output logic [2**ADDR_W-1:0]  CS,
  output logic                  W,
  output logic                  R,
  output logic [DATA_W-1:0]     D,
  output logic [DATA_W-1:0]     RDATA,
  output logic                  ACK,
  output logic                  BUSY,
  output logic                  ERR
);

  state_t              state;
  state_t              next_state;
  logic                we_l;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic                cs_en;
  logic                accept;

  assign accept = (state == IDLE) && REQ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request fields are captured only on acceptance so a busy host cannot disturb an access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else if (accept) begin
      we_l    <= WE;
      addr_l  <= ADDR;
      wdata_l <= WDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA <= '0;
    end else if (state == READ) begin
      RDATA <= Q;
    end
  end

`ifdef MEM_CTRL_VERIFY_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if (accept) begin
      ERR <= 1'b0;
    end else if (state == VERIFY) begin
      ERR <= (Q != wdata_l);
    end
  end
`else
  assign ERR = 1'b0;
`endif

  always_comb begin
    next_state = state;
    W          = 1'b0;
    R          = 1'b0;
    D          = '0;
    ACK        = 1'b0;
    BUSY       = (state != IDLE);
    cs_en      = in_access(state);
    case (state)
      IDLE: begin
        if (REQ) begin
          next_state = SETUP;
        end
      end
      SETUP: begin
        D          = wdata_l;
        next_state = we_l ? WRITE : READ;
      end
      WRITE: begin
        D = wdata_l;
        W = 1'b1;
`ifdef MEM_CTRL_VERIFY_EN
        next_state = VERIFY;
`else
        next_state = DONE;
`endif
      end
      READ: begin
        D          = wdata_l;
        R          = 1'b1;
        next_state = DONE;
      end
`ifdef MEM_CTRL_VERIFY_EN
      VERIFY: begin
        D          = wdata_l;
        R          = 1'b1;
        next_state = DONE;
      end
`endif
      DONE: begin
        ACK        = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_addr_decoder (
    .addr   (addr_l),
    .en     (cs_en),
    .onehot (CS)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a behavioural cell array and reference model.
// Expected latency and ERR follow MEM_CTRL_VERIFY_EN when the bench is built with it.
module tb_mem_access_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int WORDS  = 16;
`ifdef MEM_CTRL_VERIFY_EN
  localparam bit VERIFY_ON = 1'b1;
`else
  localparam bit VERIFY_ON = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              REQ;
  logic              WE;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W-1:0] Q;
  logic [WORDS-1:0]  CS;
  logic              W;
  logic              R;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] RDATA;
  logic              ACK;
  logic              BUSY;
  logic              ERR;

  logic              q_force = 1'b0;
  logic [DATA_W-1:0] cells   [WORDS];
  logic [DATA_W-1:0] ref_mem [WORDS];
  logic [DATA_W-1:0] ref_rdata;
  logic              ref_err;
  int                n_cmp  = 0;
  int                n_err  = 0;
  bit                mon_en = 1'b0;

  always #5 CLK = ~CLK;

  mem_access_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (REQ),
    .WE    (WE),
    .ADDR  (ADDR),
    .WDATA (WDATA),
    .Q     (Q),
    .CS    (CS),
    .W     (W),
    .R     (R),
    .D     (D),
    .RDATA (RDATA),
    .ACK   (ACK),
    .BUSY  (BUSY),
    .ERR   (ERR)
  );

  // Behavioural cell array; q_force models a stuck-at-0 on bit 2 of the read path.
  always @(posedge CLK) begin
    if (W) begin
      for (int i = 0; i < WORDS; i++) begin
        if (CS[i]) cells[i] <= D;
      end
    end
  end

  always_comb begin
    Q = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (CS[i]) Q = cells[i];
    end
    if (q_force) Q[2] = 1'b0;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe and select invariants hold on every cycle regardless of the transaction in flight.
  always @(negedge CLK) begin
    if (mon_en) begin
      check_output("strobe_excl", 32'(W & R), 32'd0);
      check_output("cs_onehot", ($countones(CS) <= 1) ? 32'd0 : 32'd1, 32'd0);
      if (!BUSY) check_output("idle_quiet", 32'({CS, W, R, D}), 32'd0);
    end
  end

  task automatic idle_cycles(input int n);
    REQ = 1'b0;
    repeat (n) begin
      WE = 1'($urandom); ADDR = 4'($urandom); WDATA = 8'($urandom);
      @(negedge CLK);
    end
  endtask

  // Issues one request from IDLE, checks the access cycles and the ACK cycle, ends back in IDLE.
  task automatic apply_stimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input logic bad);
    int cyc;
    int exp_lat;
    bit seen;
    exp_lat = (we && VERIFY_ON) ? 4 : 3;
    check_output("pre_idle", 32'(BUSY), 32'd0);
    REQ = 1'b1; WE = we; ADDR = addr; WDATA = wdata; q_force = bad;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 8) begin
      @(negedge CLK);
      cyc++;
      if (ACK) begin
        seen = 1'b1;
      end else begin
        check_output("cs_access", 32'(CS), 32'd1 << addr);
        check_output("busy_access", 32'(BUSY), 32'd1);
        if (we) check_output("d_write", 32'(D), 32'(wdata));
        if (cyc == 1)      check_output("strobe_setup", 32'({W, R}), 32'd0);
        else if (cyc == 2) check_output("strobe_access", 32'({W, R}), we ? 32'd2 : 32'd1);
        else               check_output("strobe_verify", 32'({W, R}), 32'd1);
        REQ = 1'($urandom); WE = 1'($urandom); ADDR = 4'($urandom); WDATA = 8'($urandom);
      end
    end
    REQ = 1'b0;
    check_output("ack_latency", 32'(cyc), 32'(exp_lat));
    if (we) ref_mem[addr] = wdata;
    else    ref_rdata = ref_mem[addr];
    ref_err = we && VERIFY_ON && bad && wdata[2];
    if (seen) begin
      check_output("rdata", 32'(RDATA), 32'(ref_rdata));
      check_output("err", 32'(ERR), 32'(ref_err));
      check_output("cs_done", 32'({CS, W, R}), 32'd0);
    end
    q_force = 1'b0;
    @(negedge CLK);
    check_output("ack_pulse", 32'(ACK), 32'd0);
    check_output("busy_idle", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int ph;
    int n_ack;
    bit req_edge;
    RST = 1'b1; REQ = 1'b0; WE = 1'b0; ADDR = '0; WDATA = '0;
    ref_rdata = '0; ref_err = 1'b0;
    repeat (2) @(negedge CLK);
    check_output("rst_cs", 32'(CS), 32'd0);
    check_output("rst_wr", 32'({W, R}), 32'd0);
    check_output("rst_d", 32'(D), 32'd0);
    check_output("rst_rdata", 32'(RDATA), 32'd0);
    check_output("rst_ack", 32'(ACK), 32'd0);
    check_output("rst_busy", 32'(BUSY), 32'd0);
    check_output("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    mon_en = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < WORDS; i++) apply_stimulus(1'b1, 4'(i), 8'($urandom), 1'b0);

    apply_stimulus(1'b1, 4'd3, 8'hA5, 1'b0);
    apply_stimulus(1'b0, 4'd3, 8'h00, 1'b0);
    check_output("wr_rd_a5", 32'(RDATA), 32'hA5);

    apply_stimulus(1'b1, 4'd0, 8'hFF, 1'b0);
    apply_stimulus(1'b1, 4'd15, 8'h00, 1'b0);
    apply_stimulus(1'b0, 4'd0, 8'h5A, 1'b0);
    check_output("iso_addr0", 32'(RDATA), 32'hFF);
    apply_stimulus(1'b0, 4'd15, 8'h5A, 1'b0);
    check_output("iso_addr15", 32'(RDATA), 32'h00);
    apply_stimulus(1'b1, 4'd7, 8'h81, 1'b0);
    check_output("rdata_hold_wr", 32'(RDATA), 32'h00);

    apply_stimulus(1'b1, 4'd9, 8'h3C, 1'b1);
    check_output("verify_bad", 32'(ERR), VERIFY_ON ? 32'd1 : 32'd0);
    apply_stimulus(1'b1, 4'd9, 8'h3C, 1'b0);
    check_output("verify_good", 32'(ERR), 32'd0);

    // REQ held across two transactions: phase 0 idle, 1 setup, 2 read, 3 done.
    ph = 0; n_ack = 0;
    REQ = 1'b1; WE = 1'b0; ADDR = 4'd5; WDATA = 8'h00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      req_edge = (i <= 8);
      if (ph == 0) ph = req_edge ? 1 : 0;
      else         ph = (ph == 3) ? 0 : ph + 1;
      if (ACK) n_ack++;
      check_output("rej_busy", 32'(BUSY), (ph != 0) ? 32'd1 : 32'd0);
      check_output("rej_ack", 32'(ACK), (ph == 3) ? 32'd1 : 32'd0);
      REQ = (i + 1 <= 8);
    end
    ref_rdata = ref_mem[5];
    ref_err = 1'b0;
    check_output("rej_ack_count", 32'(n_ack), 32'd2);
    check_output("rej_rdata", 32'(RDATA), 32'(ref_rdata));

    REQ = 1'b1; WE = 1'b0; ADDR = 4'd3;
    @(negedge CLK);
    REQ = 1'b0;
    @(negedge CLK);
    check_output("mid_read_r", 32'(R), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    check_output("abort_cs", 32'(CS), 32'd0);
    check_output("abort_r", 32'(R), 32'd0);
    check_output("abort_busy", 32'(BUSY), 32'd0);
    check_output("abort_ack", 32'(ACK), 32'd0);
    check_output("abort_rdata", 32'(RDATA), 32'd0);
    RST = 1'b0;
    ref_rdata = '0; ref_err = 1'b0;
    @(negedge CLK);
    check_output("abort_no_ack", 32'(ACK), 32'd0);
    apply_stimulus(1'b0, 4'd3, 8'h00, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      apply_stimulus(1'($urandom), 4'($urandom), 8'($urandom), 1'b0);
      idle_cycles($urandom_range(0, 2));
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
